// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory.
// One access per three cycles: grant, issue, acknowledge.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req0,
  input  logic [AW-1:0] i_addr0,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW/8-1:0] i_wmask0,
  output logic          o_ack0,
  output logic [DW-1:0] o_rdata0,
  input  logic          i_req1,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata1,
  input  logic [DW/8-1:0] i_wmask1,
  output logic          o_ack1,
  output logic [DW-1:0] o_rdata1,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [DW/8-1:0] o_mem_wmask,
  output logic          o_mem_ren,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t r_state;
  logic   r_ptr;
  logic   r_win;
  logic   r_rd;

  logic            w_any;
  logic            w_gnt1;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic [DW/8-1:0] w_wmask;

  assign w_any   = i_req0 | i_req1;
  // r_ptr=1 hands priority to port 1 when both request
  assign w_gnt1  = i_req1 & (~i_req0 | r_ptr);
  assign w_addr  = w_gnt1 ? i_addr1  : i_addr0;
  assign w_wdata = w_gnt1 ? i_wdata1 : i_wdata0;
  assign w_wmask = w_gnt1 ? i_wmask1 : i_wmask0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_win       <= 1'b0;
      r_rd        <= 1'b0;
      o_ack0      <= 1'b0;
      o_ack1      <= 1'b0;
      o_mem_ren   <= 1'b0;
      o_mem_wmask <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_ack0      <= 1'b0;
      o_ack1      <= 1'b0;
      o_mem_ren   <= 1'b0;
      o_mem_wmask <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win       <= w_gnt1;
            r_ptr       <= ~w_gnt1;
            r_rd        <= (w_wmask == '0);
            o_mem_addr  <= w_addr;
            o_mem_wdata <= w_wdata;
            o_mem_wmask <= w_wmask;
            o_mem_ren   <= (w_wmask == '0);
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          o_ack0  <= ~r_win;
          o_ack1  <= r_win;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // memory data arrives in the ack cycle, so it is passed through
  assign o_rdata0 = (o_ack0 && r_rd) ? i_mem_rdata : '0;
  assign o_rdata1 = (o_ack1 && r_rd) ? i_mem_rdata : '0;
  assign o_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory accesses and
// acks are queued at stimulus time and retired by a negedge monitor.
module tb_mem_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_req0, i_req1;
  logic [31:0] i_addr0, i_addr1;
  logic [31:0] i_wdata0, i_wdata1;
  logic [3:0]  i_wmask0, i_wmask1;
  logic        o_ack0, o_ack1;
  logic [31:0] o_rdata0, o_rdata1;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        o_mem_ren;
  logic [31:0] i_mem_rdata;
  logic        o_busy;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0(i_req0), .i_addr0(i_addr0),
    .i_wdata0(i_wdata0), .i_wmask0(i_wmask0),
    .o_ack0(o_ack0), .o_rdata0(o_rdata0),
    .i_req1(i_req1), .i_addr1(i_addr1),
    .i_wdata1(i_wdata1), .i_wmask1(i_wmask1),
    .o_ack1(o_ack1), .o_rdata1(o_rdata1),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_wmask(o_mem_wmask), .o_mem_ren(o_mem_ren),
    .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } macc_t;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] rdata;
  } ack_t;

  macc_t mq[$];
  ack_t  aq[$];
  macc_t m;
  ack_t  a;
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    c;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [31:0] ad);
    if (ad == 32'h10) return 32'hDEADBEEF;
    return (ad * 32'h01000193) ^ 32'h5A5A0000;
  endfunction

  always @(posedge i_clk)
    i_mem_rdata <= o_mem_ren ? pat(o_mem_addr) : 32'hBAD00BAD;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  task automatic exp_txn(input int p, input logic [31:0] ad,
                         input logic [31:0] d, input logic [3:0] mk,
                         input int ic);
    mq.push_back('{ic, ad, d, mk});
    aq.push_back('{ic + 1, p, (mk == 4'h0) ? pat(ad) : 32'h0});
  endtask

  task automatic set_req(input int p, input logic [31:0] ad,
                         input logic [31:0] d, input logic [3:0] mk);
    if (p == 0) begin
      i_addr0 = ad; i_wdata0 = d; i_wmask0 = mk; i_req0 = 1'b1;
    end else begin
      i_addr1 = ad; i_wdata1 = d; i_wmask1 = mk; i_req1 = 1'b1;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) i_req0 = 1'b0;
    else        i_req1 = 1'b0;
  endtask

  task automatic wait_ack(input int p);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge i_clk);
      if ((p == 0) ? o_ack0 : o_ack1) seen = 1'b1;
    end
    chk($sformatf("ack_wait_p%0d", p), seen, 1);
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_mem_ren || o_mem_wmask != 4'h0) begin
        if (mq.size() == 0) chk("mem_unexp", 1, 0);
        else begin
          m = mq.pop_front();
          chk("mem_cyc", cyc, m.cyc);
          chk("mem_addr", o_mem_addr, m.addr);
          chk("mem_ren", o_mem_ren, m.wmask == 4'h0);
          chk("mem_wmask", o_mem_wmask, m.wmask);
          if (m.wmask != 4'h0) chk("mem_wdata", o_mem_wdata, m.wdata);
        end
      end
      if (!o_ack0) chk("rd0_zero", o_rdata0, 0);
      if (!o_ack1) chk("rd1_zero", o_rdata1, 0);
      if (o_ack0 || o_ack1) begin
        chk("ack_excl", o_ack0 & o_ack1, 0);
        if (aq.size() == 0) chk("ack_unexp", 1, 0);
        else begin
          a = aq.pop_front();
          chk("ack_cyc", cyc, a.cyc);
          chk("ack_port", o_ack1, a.port == 1);
          chk("ack_rdata", (a.port == 1) ? o_rdata1 : o_rdata0,
              a.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    i_req0 = 1'b1; i_req1 = 1'b0;
    i_addr0 = 32'h8; i_wdata0 = 32'h0; i_wmask0 = 4'h0;
    i_addr1 = 32'h0; i_wdata1 = 32'h0; i_wmask1 = 4'h0;
    #1;
    chk("rst_ack0", o_ack0, 0);
    chk("rst_ack1", o_ack1, 0);
    chk("rst_rdata0", o_rdata0, 0);
    chk("rst_rdata1", o_rdata1, 0);
    chk("rst_ren", o_mem_ren, 0);
    chk("rst_wmask", o_mem_wmask, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0);
    chk("rst_busy", o_busy, 0);
    repeat (2) @(negedge i_clk);
    chk("rst_hold_busy", o_busy, 0);
    chk("rst_hold_ren", o_mem_ren, 0);
    drop(0);
    i_rst = 1'b0;

    // port 0 read of 0x10
    @(negedge i_clk); c = cyc;
    exp_txn(0, 32'h10, 32'h0, 4'h0, c + 1);
    set_req(0, 32'h10, 32'h0, 4'h0);
    @(negedge i_clk);
    chk("busy_issue", o_busy, 1);
    wait_ack(0); drop(0);
    chk("addr_hold", o_mem_addr, 32'h10);

    // port 1 partial write
    @(negedge i_clk); c = cyc;
    exp_txn(1, 32'h20, 32'h12345678, 4'b0011, c + 1);
    set_req(1, 32'h20, 32'h12345678, 4'b0011);
    wait_ack(1); drop(1);
    chk("wmask_done", o_mem_wmask, 0);

    // fields change after grant: latched copy wins
    @(negedge i_clk); c = cyc;
    exp_txn(0, 32'h40, 32'h0, 4'h0, c + 1);
    set_req(0, 32'h40, 32'h0, 4'h0);
    @(negedge i_clk);
    i_addr0 = 32'h44; i_wmask0 = 4'hF;
    wait_ack(0); drop(0);

    // request dropped after grant still completes
    @(negedge i_clk); c = cyc;
    exp_txn(1, 32'h30, 32'h0, 4'h0, c + 1);
    set_req(1, 32'h30, 32'h0, 4'h0);
    @(negedge i_clk);
    drop(1);
    wait_ack(1);

    // both ports continuously from reset: 0,1,0,1
    @(negedge i_clk); i_rst = 1'b1;
    @(negedge i_clk); i_rst = 1'b0;
    @(negedge i_clk); c = cyc;
    exp_txn(0, 32'h100, 32'h0, 4'h0, c + 1);
    exp_txn(1, 32'h200, 32'hA5A50001, 4'b1100, c + 4);
    exp_txn(0, 32'h104, 32'hCAFEF00D, 4'b1111, c + 7);
    exp_txn(1, 32'h204, 32'h0, 4'h0, c + 10);
    fork
      begin
        set_req(0, 32'h100, 32'h0, 4'h0);
        wait_ack(0);
        set_req(0, 32'h104, 32'hCAFEF00D, 4'b1111);
        wait_ack(0); drop(0);
      end
      begin
        set_req(1, 32'h200, 32'hA5A50001, 4'b1100);
        wait_ack(1);
        set_req(1, 32'h204, 32'h0, 4'h0);
        wait_ack(1); drop(1);
      end
    join

    // reset during ISSUE of a write abandons it
    @(negedge i_clk); c = cyc;
    mq.push_back('{c + 1, 32'h300, 32'h11223344, 4'hF});
    set_req(0, 32'h300, 32'h11223344, 4'hF);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    drop(0);
    #1;
    chk("rst_issue_wmask", o_mem_wmask, 0);
    chk("rst_issue_busy", o_busy, 0);
    @(negedge i_clk);
    chk("rst_issue_ack0", o_ack0, 0);
    @(negedge i_clk); i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    c = cyc;
    exp_txn(1, 32'h50, 32'h0, 4'h0, c + 1);
    set_req(1, 32'h50, 32'h0, 4'h0);
    wait_ack(1); drop(1);

    // port 1 alone, four back-to-back accesses
    @(negedge i_clk); c = cyc;
    for (int i = 0; i < 4; i++)
      exp_txn(1, 32'h60 + 4 * i, 32'h1000 + i,
              (i % 2 == 1) ? 4'b0101 : 4'h0, c + 1 + 3 * i);
    for (int i = 0; i < 4; i++) begin
      set_req(1, 32'h60 + 4 * i, 32'h1000 + i,
              (i % 2 == 1) ? 4'b0101 : 4'h0);
      wait_ack(1);
    end
    drop(1);

    repeat (5) @(negedge i_clk);
    chk("mq_left", mq.size(), 0);
    chk("aq_left", aq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, which is the address width.
REQ-002 SHALL have parameter DW, default 32, which is the data width; DW/8 byte lanes.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 i_req0  input  1  port 0 (CPU) request; held high with stable fields until o_ack0.
REQ-006 i_addr0 / i_wdata0 / i_wmask0  input  AW / DW / DW/8  port 0 address, write data, byte write mask (0 = read).
REQ-007 o_ack0  output  1  port 0 one-cycle completion pulse.
REQ-008 o_rdata0  output  DW  port 0 read data; valid while o_ack0=1.
REQ-009 i_req1, i_addr1, i_wdata1, i_wmask1, o_ack1, o_rdata1 SHALL have the same widths and meanings as port 0, for port 1 (loader/debug).
REQ-010 o_mem_addr  output  AW  memory address.
REQ-011 o_mem_wdata / o_mem_wmask  output  DW / DW/8  memory write data and byte mask.
REQ-012 o_mem_ren  output  1  memory read enable.
REQ-013 i_mem_rdata  input  DW  memory read data, valid one cycle after o_mem_ren.
REQ-014 o_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 FSM states: IDLE, ISSUE, DONE; encoding is free; no other reachable states.
REQ-016 IDLE: if any i_reqN is high, the block SHALL register winner index, address, wdata and wmask, then go to ISSUE; otherwise stay in IDLE.
REQ-017 Arbitration: round-robin with a 1-bit priority pointer. With both requests high, the pointer port wins. A single requester wins regardless of the pointer.
REQ-018 Pointer SHALL move to the non-winning port on every grant, including an uncontested grant.
REQ-019 ISSUE (exactly 1 cycle): o_mem_addr = latched addr.
  - Read (wmask==0): o_mem_ren=1, o_mem_wmask=0.
  - Write: o_mem_wmask=latched mask, o_mem_wdata=latched wdata, o_mem_ren=0.
  - Next state DONE.
REQ-020 DONE (exactly 1 cycle): o_ackN=1 for the winner only; o_rdataN=i_mem_rdata for reads, 0 for writes. Next state IDLE.
REQ-021 Latency: request sampled in IDLE at edge k; ack high in cycle k+2; next grant sampled at edge k+3. Max throughput 1 access per 3 cycles.
REQ-022 Outside ISSUE: o_mem_ren=0 and o_mem_wmask=0. o_mem_addr and o_mem_wdata SHALL hold their last value.
REQ-023 o_ack0 and o_ack1 SHALL never be high in the same cycle; each ack SHALL be high for exactly one cycle per grant.
REQ-024 Request deasserted after grant: the transaction SHALL complete and the ack SHALL still be issued. Request fields changed after grant SHALL be ignored (latched copy used).
REQ-025 Request held high in the ack cycle: treated as a new request in the following IDLE cycle.
REQ-026 o_rdataN SHALL be 0 when o_ackN=0.
REQ-027 A write SHALL never drive o_mem_ren; a read SHALL never drive a nonzero o_mem_wmask.

Reset
REQ-028 While i_rst=1, regardless of clock: state=IDLE, pointer=port 0, o_ack0=o_ack1=0, o_rdata0=o_rdata1=0, o_mem_ren=0, o_mem_wmask=0, o_mem_addr=0, o_mem_wdata=0, o_busy=0.
REQ-029 Reset asserted in ISSUE or DONE: the in-flight transaction SHALL be abandoned with no ack issued, including after reset release. A write in ISSUE at reset assertion SHALL have its wmask forced to 0 immediately (asynchronously).
REQ-030 First grant after reset release: port 0 priority.

Verification
REQ-031 Port 0 read addr 0x10, memory returns 0xDEADBEEF: o_mem_ren=1 at cycle +1; o_ack0=1 and o_rdata0=0xDEADBEEF at cycle +2; o_ack1 stays 0.
REQ-032 Port 1 write addr 0x20, data 0x12345678, mask 4'b0011: o_mem_wmask=4'b0011 and o_mem_wdata=0x12345678 for one cycle; o_mem_ren=0; o_ack1 one cycle later; o_rdata1=0.
REQ-033 Both ports request continuously from reset: grant order 0,1,0,1; acks spaced 3 cycles apart, never overlapping.
REQ-034 Port 0 changes addr to 0x44 after grant at 0x40: memory sees 0x40; ack still issued.
REQ-035 i_rst pulsed during ISSUE of a write: o_mem_wmask drops to 0 in the same cycle; no ack; after release, a port 1 request is served with ack at +2.
REQ-036 Only port 1 requests for 4 back-to-back transactions: every request served with no starvation despite pointer toggling; each ack occurs 3 cycles after the previous one.
